// File: rtl/pipeline_hazard_controller.sv
// Hazard detection, stall/flush sequencing and forwarding selects for a 5-stage RISC-V pipeline.
// Optional macro HAZARD_FORWARD_EN: when defined, forwarding is present and only load-use stalls.
module pipeline_hazard_controller #(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_multicycle,
    input  logic             ex_branch_taken,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             id_ex_hold,
    output logic             ex_busy,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count
);
    typedef enum logic [1:0] {RUN = 2'd0, MC_BUSY = 2'd1, FLUSH = 2'd2} state_t;

    localparam logic [3:0]       MC_CNT_INIT = 4'(MC_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t     state, next_state;
    logic [3:0] mc_cnt;
    // Shadow slots; WB is not tracked because the register file writes through.
    logic [4:0] ex_rd, mem_rd;
    logic       ex_rw, ex_mr, mem_rw;
    logic       a_ex, b_ex, a_mem, b_mem;
    logic       raw, hazard, load_ex;

    function automatic logic reg_match(input logic [4:0] rd, input logic rw,
                                       input logic [4:0] rs, input logic used);
        return used && rw && (rd != 5'd0) && (rd == rs);
    endfunction

    assign a_ex  = reg_match(ex_rd,  ex_rw,  id_rs1, id_rs1_used);
    assign b_ex  = reg_match(ex_rd,  ex_rw,  id_rs2, id_rs2_used);
    assign a_mem = reg_match(mem_rd, mem_rw, id_rs1, id_rs1_used);
    assign b_mem = reg_match(mem_rd, mem_rw, id_rs2, id_rs2_used);

    always_comb begin
        next_state   = state;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        id_ex_hold   = 1'b0;
        ex_busy      = 1'b0;
        hazard       = 1'b0;
        if (reset) begin
            case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        next_state   = FLUSH;
                    end else if (raw) begin
                        hazard       = 1'b1;
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (id_valid && id_multicycle) begin
                        next_state = MC_BUSY;
                    end
                end
                MC_BUSY: begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_hold  = 1'b1;
                    ex_busy     = 1'b1;
                    if (mc_cnt == 4'd0) next_state = RUN;
                end
                FLUSH: begin
                    // Squash the wrong-path instruction that was sitting in ID.
                    id_ex_bubble = 1'b1;
                    next_state   = RUN;
                end
                default: next_state = RUN;
            endcase
        end
    end

    assign load_ex = (state != MC_BUSY) && id_valid && !id_ex_bubble;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            mc_cnt      <= 4'd0;
            ex_rd       <= 5'd0;
            ex_rw       <= 1'b0;
            ex_mr       <= 1'b0;
            mem_rd      <= 5'd0;
            mem_rw      <= 1'b0;
            stall_count <= '0;
        end else begin
            state <= next_state;
            if (state == MC_BUSY) begin
                if (mc_cnt == 4'd0) begin
                    // Last busy cycle: the op moves on to MEM and EX empties.
                    mem_rd <= ex_rd;
                    mem_rw <= ex_rw;
                    ex_rd  <= 5'd0;
                    ex_rw  <= 1'b0;
                    ex_mr  <= 1'b0;
                end else begin
                    mem_rd <= 5'd0;
                    mem_rw <= 1'b0;
                    mc_cnt <= mc_cnt - 4'd1;
                end
            end else begin
                mem_rd <= ex_rd;
                mem_rw <= ex_rw;
                ex_rd  <= load_ex ? id_rd : 5'd0;
                ex_rw  <= load_ex && id_reg_write;
                ex_mr  <= load_ex && id_mem_read;
                if (load_ex && id_multicycle) mc_cnt <= MC_CNT_INIT;
            end
            if (hazard && (stall_count != '1)) stall_count <= stall_count + CNT_ONE;
        end
    end

`ifdef HAZARD_FORWARD_EN
    logic [1:0] sel_a, sel_b;

    assign raw   = id_valid && ex_mr && (a_ex || b_ex);
    assign sel_a = a_ex ? 2'b10 : (a_mem ? 2'b01 : 2'b00);
    assign sel_b = b_ex ? 2'b10 : (b_mem ? 2'b01 : 2'b00);

    // Selects belong to the instruction in EX, so they move only when EX moves.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwd_a <= 2'b00;
            fwd_b <= 2'b00;
        end else if (state == MC_BUSY) begin
            if (mc_cnt == 4'd0) begin
                fwd_a <= 2'b00;
                fwd_b <= 2'b00;
            end
        end else begin
            fwd_a <= load_ex ? sel_a : 2'b00;
            fwd_b <= load_ex ? sel_b : 2'b00;
        end
    end
`else
    assign raw   = id_valid && (a_ex || b_ex || a_mem || b_mem);
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed testbench for pipeline_hazard_controller; expectations follow HAZARD_FORWARD_EN.
module tb_pipeline_hazard_controller;
    localparam int MC_LAT = 4;
    localparam int CW     = 10;
`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int LU_STALLS  = FWD ? 1 : 2;
    localparam int ALU_STALLS = FWD ? 0 : 2;

    // ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, id_ex_hold, ex_busy}
    localparam logic [5:0] CTL_NONE  = 6'b000000;
    localparam logic [5:0] CTL_STALL = 6'b110100;
    localparam logic [5:0] CTL_FLUSH = 6'b001100;
    localparam logic [5:0] CTL_BUB   = 6'b000100;
    localparam logic [5:0] CTL_BUSY  = 6'b110011;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_mem_read, id_multicycle;
    logic [4:0]    id_rs1, id_rs2, id_rd;
    logic          ex_branch_taken;
    logic          pc_stall, if_id_stall, if_id_flush, id_ex_bubble, id_ex_hold, ex_busy;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_count;
    logic [5:0]    ctl;
    logic [3:0]    fwd;
    int            n_chk = 0;
    int            n_pass = 0;

    assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, id_ex_hold, ex_busy};
    assign fwd = {fwd_a, fwd_b};

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.MC_LATENCY(MC_LAT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_multicycle(id_multicycle), .ex_branch_taken(ex_branch_taken),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .id_ex_hold(id_ex_hold), .ex_busy(ex_busy),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
    );

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic [4:0] rd, input logic rw,
                          input logic mr, input logic mc);
        id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr; id_multicycle = mc;
    endtask

    task automatic set_nop();
        id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        id_rd = 5'd0; id_reg_write = 1'b0; id_mem_read = 1'b0; id_multicycle = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_nop();
        ex_branch_taken = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1);
        ex_branch_taken = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        n_chk++; if (ctl !== CTL_NONE) $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_NONE); else n_pass++;
        n_chk++; if (fwd !== 4'b0000) $display("FAIL reset_fwd: got %b expected 0000", fwd); else n_pass++;
        n_chk++; if (stall_count !== '0) $display("FAIL reset_count: got %0d expected 0", stall_count); else n_pass++;
        tick();
        reset = 1'b1;
        ex_branch_taken = 1'b0;
        set_id(5'd2, 5'd3, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_chk++; if (ctl !== CTL_NONE) $display("FAIL reset_run0: got %b expected %b", ctl, CTL_NONE); else n_pass++;
        tick();
        set_id(5'd5, 5'd6, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_chk++; if (ctl !== CTL_NONE) $display("FAIL reset_run1: got %b expected %b", ctl, CTL_NONE); else n_pass++;
        tick();
        set_nop();
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);  // lw x5,0(x2)
        @(negedge clk);
        n_chk++; if (ctl !== CTL_NONE) $display("FAIL lu_lw: got %b expected %b", ctl, CTL_NONE); else n_pass++;
        tick();
        set_id(5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);  // add x6,x5,x1
        for (int i = 0; i < LU_STALLS; i++) begin
            @(negedge clk);
            n_chk++; if (ctl !== CTL_STALL) $display("FAIL lu_stall%0d: got %b expected %b", i, ctl, CTL_STALL); else n_pass++;
            tick();
        end
        @(negedge clk);
        n_chk++; if (ctl !== CTL_NONE) $display("FAIL lu_issue: got %b expected %b", ctl, CTL_NONE); else n_pass++;
        tick();
        set_nop();
        @(negedge clk);
        n_chk++; if (fwd !== (FWD ? 4'b0100 : 4'b0000)) $display("FAIL lu_fwd: got %b expected %b", fwd, (FWD ? 4'b0100 : 4'b0000)); else n_pass++;
        n_chk++; if (stall_count !== CW'(LU_STALLS)) $display("FAIL lu_count: got %0d expected %0d", stall_count, LU_STALLS); else n_pass++;
    endtask

    task automatic test_alu_raw();
        do_reset();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);  // add x5,x1,x2
        @(negedge clk);
        n_chk++; if (ctl !== CTL_NONE) $display("FAIL alu_add: got %b expected %b", ctl, CTL_NONE); else n_pass++;
        tick();
        set_id(5'd5, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);  // sub x7,x5,x5
        for (int i = 0; i < ALU_STALLS; i++) begin
            @(negedge clk);
            n_chk++; if (ctl !== CTL_STALL) $display("FAIL alu_stall%0d: got %b expected %b", i, ctl, CTL_STALL); else n_pass++;
            tick();
        end
        @(negedge clk);
        n_chk++; if (ctl !== CTL_NONE) $display("FAIL alu_issue: got %b expected %b", ctl, CTL_NONE); else n_pass++;
        tick();
        set_nop();
        @(negedge clk);
        n_chk++; if (fwd !== (FWD ? 4'b1010 : 4'b0000)) $display("FAIL alu_fwd: got %b expected %b", fwd, (FWD ? 4'b1010 : 4'b0000)); else n_pass++;
        n_chk++; if (stall_count !== CW'(ALU_STALLS)) $display("FAIL alu_count: got %0d expected %0d", stall_count, ALU_STALLS); else n_pass++;
    endtask

    task automatic test_multicycle();
        do_reset();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);  // mul x8,x1,x2
        @(negedge clk);
        n_chk++; if (ctl !== CTL_NONE) $display("FAIL mc_issue: got %b expected %b", ctl, CTL_NONE); else n_pass++;
        tick();
        set_id(5'd8, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);  // add x10,x8,x0
        for (int i = 0; i < MC_LAT; i++) begin
            ex_branch_taken = (i == 1);
            @(negedge clk);
            n_chk++; if (ctl !== CTL_BUSY) $display("FAIL mc_busy%0d: got %b expected %b", i, ctl, CTL_BUSY); else n_pass++;
            tick();
        end
        ex_branch_taken = 1'b0;
        for (int i = 0; i < (FWD ? 0 : 1); i++) begin
            @(negedge clk);
            n_chk++; if (ctl !== CTL_STALL) $display("FAIL mc_dep_stall: got %b expected %b", ctl, CTL_STALL); else n_pass++;
            tick();
        end
        @(negedge clk);
        n_chk++; if (ctl !== CTL_NONE) $display("FAIL mc_dep_issue: got %b expected %b", ctl, CTL_NONE); else n_pass++;
        tick();
        set_nop();
        @(negedge clk);
        n_chk++; if (fwd !== (FWD ? 4'b0100 : 4'b0000)) $display("FAIL mc_fwd: got %b expected %b", fwd, (FWD ? 4'b0100 : 4'b0000)); else n_pass++;
        n_chk++; if (stall_count !== CW'(FWD ? 0 : 1)) $display("FAIL mc_count: got %0d expected %0d", stall_count, (FWD ? 0 : 1)); else n_pass++;
    endtask

    task automatic test_branch();
        do_reset();
        set_id(5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);  // lw x5
        tick();
        set_id(5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);  // dependent add
        ex_branch_taken = 1'b1;
        @(negedge clk);
        n_chk++; if (ctl !== CTL_FLUSH) $display("FAIL br_flush: got %b expected %b", ctl, CTL_FLUSH); else n_pass++;
        tick();
        ex_branch_taken = 1'b0;
        @(negedge clk);
        n_chk++; if (ctl !== CTL_BUB) $display("FAIL br_squash: got %b expected %b", ctl, CTL_BUB); else n_pass++;
        tick();
        set_nop();
        @(negedge clk);
        n_chk++; if (ctl !== CTL_NONE) $display("FAIL br_after: got %b expected %b", ctl, CTL_NONE); else n_pass++;
        n_chk++; if (stall_count !== '0) $display("FAIL br_count: got %0d expected 0", stall_count); else n_pass++;
        n_chk++; if (fwd !== 4'b0000) $display("FAIL br_fwd: got %b expected 0000", fwd); else n_pass++;
    endtask

    task automatic test_x0();
        do_reset();
        set_id(5'd2, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);  // lw x0
        tick();
        set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);  // add x1,x0,x0
        @(negedge clk);
        n_chk++; if (ctl !== CTL_NONE) $display("FAIL x0_stall: got %b expected %b", ctl, CTL_NONE); else n_pass++;
        tick();
        set_nop();
        @(negedge clk);
        n_chk++; if (fwd !== 4'b0000) $display("FAIL x0_fwd: got %b expected 0000", fwd); else n_pass++;
        n_chk++; if (stall_count !== '0) $display("FAIL x0_count: got %0d expected 0", stall_count); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_id(5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);  // lw x5
        tick();
        set_id(5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1);  // mul x6,x5,x1
        for (int i = 0; i < LU_STALLS; i++) tick();
        tick();
        @(negedge clk);
        n_chk++; if (ctl !== CTL_BUSY) $display("FAIL rm_busy: got %b expected %b", ctl, CTL_BUSY); else n_pass++;
        n_chk++; if (stall_count !== CW'(LU_STALLS)) $display("FAIL rm_count_pre: got %0d expected %0d", stall_count, LU_STALLS); else n_pass++;
        n_chk++; if (fwd !== (FWD ? 4'b0100 : 4'b0000)) $display("FAIL rm_fwd_pre: got %b expected %b", fwd, (FWD ? 4'b0100 : 4'b0000)); else n_pass++;
        tick();
        reset = 1'b0;
        ex_branch_taken = 1'b1;
        #1;
        n_chk++; if (ctl !== CTL_NONE) $display("FAIL rm_ctl: got %b expected %b", ctl, CTL_NONE); else n_pass++;
        n_chk++; if (stall_count !== '0) $display("FAIL rm_count: got %0d expected 0", stall_count); else n_pass++;
        n_chk++; if (fwd !== 4'b0000) $display("FAIL rm_fwd: got %b expected 0000", fwd); else n_pass++;
        tick();
        reset = 1'b1;
        ex_branch_taken = 1'b0;
        set_id(5'd2, 5'd3, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++; if (ctl !== CTL_NONE) $display("FAIL rm_run%0d: got %b expected %b", i, ctl, CTL_NONE); else n_pass++;
            tick();
            set_id(5'(4 + 3 * i), 5'(5 + 3 * i), 1'b1, 1'b1, 5'(6 + 3 * i), 1'b1, 1'b0, 1'b0);
        end
        set_nop();
        @(negedge clk);
        n_chk++; if (stall_count !== '0) $display("FAIL rm_count_post: got %0d expected 0", stall_count); else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        set_id(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);  // lw x5,0(x5) repeated
        for (int i = 0; i < 20; i++) tick();
        @(negedge clk);
        n_chk++; if (stall_count !== CW'(FWD ? 10 : 13)) $display("FAIL sat_partial: got %0d expected %0d", stall_count, (FWD ? 10 : 13)); else n_pass++;
        for (int i = 0; i < 2200; i++) tick();
        @(negedge clk);
        n_chk++; if (stall_count !== {CW{1'b1}}) $display("FAIL sat_hold: got %0d expected %0d", stall_count, (1 << CW) - 1); else n_pass++;
        tick();
        set_nop();
    endtask

    initial begin
        set_nop();
        ex_branch_taken = 1'b0;
        test_reset();
        test_load_use();
        test_alu_raw();
        test_multicycle();
        test_branch();
        test_x0();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule
